// File: rtl/tl_monitor.sv
`timescale 1ns/1ps
// tl_monitor: safety monitor for a two-road traffic-light controller.
// Build option: define TL_MON_WDOG_EN to include the all-red watchdog (fault code 5).
//
// state   | meaning
// S_INIT  | capture current lights as reference, no checks
// S_RUN   | check each sample: conflict, illegal change, short yellow, all-red
// S_FAULT | first fault latched, flash red until cleared with both roads red
module tl_monitor #(
    parameter int YMIN       = 2,
    parameter int ALLRED_MAX = 8,
    parameter int FLASH_DIV  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] La,
    input  logic [1:0] Lb,
    input  logic       clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash
);

    localparam logic [1:0] GRN = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] LFT = 2'b10;
    localparam logic [1:0] RED = 2'b11;

    localparam int YW = $clog2(YMIN + 2);
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    typedef enum logic [1:0] {S_INIT, S_RUN, S_FAULT} state_t;

    state_t        state;
    logic [1:0]    la_q, lb_q;
    logic [YW-1:0] ya_cnt, yb_cnt, ya_next, yb_next;
    logic [FW-1:0] fl_cnt;
    logic          conflict, bad_a, bad_b, short_y, wdog_hit;
    logic [2:0]    viol;

    function automatic logic legal(input logic [1:0] prev, input logic [1:0] cur);
        if (prev == cur) return 1'b1;
        case ({prev, cur})
            {RED, GRN}, {RED, LFT}, {GRN, YEL}, {LFT, YEL}, {YEL, RED}: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

`ifdef TL_MON_WDOG_EN
    localparam int AW = $clog2(ALLRED_MAX + 2);
    logic [AW-1:0] ar_cnt, ar_next;

    always_comb begin
        ar_next = '0;
        if (La == RED && Lb == RED)
            ar_next = (ar_cnt == AW'(ALLRED_MAX + 1)) ? ar_cnt : ar_cnt + AW'(1);
    end
    assign wdog_hit = ar_next > AW'(ALLRED_MAX);
`else
    // watchdog not built; the parameter only shapes the optional counter
    assign wdog_hit = (ALLRED_MAX < 0);
`endif

    always_comb begin
        ya_next = '0;
        yb_next = '0;
        if (La == YEL) ya_next = (ya_cnt == YW'(YMIN)) ? ya_cnt : ya_cnt + YW'(1);
        if (Lb == YEL) yb_next = (yb_cnt == YW'(YMIN)) ? yb_cnt : yb_cnt + YW'(1);

        conflict = (La != RED) && (Lb != RED);
        bad_a    = !legal(la_q, La);
        bad_b    = !legal(lb_q, Lb);
        short_y  = (la_q == YEL && La != YEL && ya_cnt < YW'(YMIN)) ||
                   (lb_q == YEL && Lb != YEL && yb_cnt < YW'(YMIN));

        viol = 3'd0;
        if (conflict)      viol = 3'd1;
        else if (bad_a)    viol = 3'd2;
        else if (bad_b)    viol = 3'd3;
        else if (short_y)  viol = 3'd4;
        else if (wdog_hit) viol = 3'd5;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_INIT;
            la_q       <= RED;
            lb_q       <= RED;
            ya_cnt     <= '0;
            yb_cnt     <= '0;
            fl_cnt     <= '0;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            flash      <= 1'b0;
`ifdef TL_MON_WDOG_EN
            ar_cnt     <= '0;
`endif
        end else begin
            case (state)
                S_INIT: begin
                    la_q   <= La;
                    lb_q   <= Lb;
                    ya_cnt <= ya_next;
                    yb_cnt <= yb_next;
`ifdef TL_MON_WDOG_EN
                    ar_cnt <= ar_next;
`endif
                    state  <= S_RUN;
                end
                S_RUN: begin
                    la_q   <= La;
                    lb_q   <= Lb;
                    ya_cnt <= ya_next;
                    yb_cnt <= yb_next;
`ifdef TL_MON_WDOG_EN
                    ar_cnt <= ar_next;
`endif
                    if (viol != 3'd0) begin
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        fault_code <= viol;
                        flash      <= 1'b1;
                        fl_cnt     <= FW'(FLASH_DIV - 1);
                    end
                end
                S_FAULT: begin
                    if (clr && La == RED && Lb == RED) begin
                        state      <= S_INIT;
                        ya_cnt     <= '0;
                        yb_cnt     <= '0;
                        fl_cnt     <= '0;
                        fault      <= 1'b0;
                        fault_code <= 3'd0;
                        flash      <= 1'b0;
`ifdef TL_MON_WDOG_EN
                        ar_cnt     <= '0;
`endif
                    end else if (fl_cnt == '0) begin
                        flash  <= ~flash;
                        fl_cnt <= FW'(FLASH_DIV - 1);
                    end else begin
                        fl_cnt <= fl_cnt - FW'(1);
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_monitor.sv
`timescale 1ns/1ps
// tb_tl_monitor: directed scenarios plus randomized light sequences,
// compared every cycle against a sample-level reference model.
module tb_tl_monitor;

    localparam int YMIN       = 2;
    localparam int ALLRED_MAX = 8;
    localparam int FLASH_DIV  = 4;
    localparam logic [1:0] G = 2'b00, Y = 2'b01, L = 2'b10, R = 2'b11;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] La, Lb;
    logic       clr;
    logic       fault;
    logic [2:0] fault_code;
    logic       flash;

    int n_checks = 0;
    int n_pass   = 0;

    tl_monitor #(.YMIN(YMIN), .ALLRED_MAX(ALLRED_MAX), .FLASH_DIV(FLASH_DIV)) dut (
        .clk(clk), .reset_n(reset_n), .La(La), .Lb(Lb), .clr(clr),
        .fault(fault), .fault_code(fault_code), .flash(flash)
    );

    always #5 clk = ~clk;

    typedef enum int {M_INIT, M_RUN, M_FAULT} mmode_t;
    mmode_t     m_mode;
    logic [1:0] m_pa, m_pb;
    int         m_ya, m_yb, m_ar, m_code, m_fcyc;
    bit         legal_tbl [4][4];
    logic [1:0] cur_a, cur_b;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        m_mode = M_INIT;
        m_pa = R; m_pb = R;
        m_ya = 0; m_yb = 0; m_ar = 0;
        m_code = 0; m_fcyc = 0;
    endfunction

    function automatic bit model_legal(input logic [1:0] p, input logic [1:0] c);
        return (p == c) || legal_tbl[p][c];
    endfunction

    // run lengths are plain unbounded counts of consecutive samples
    function automatic void model_step(input logic [1:0] a, input logic [1:0] b, input logic c);
        bit v [1:5];
        int nya, nyb, nar, first;
        nya = (a == Y) ? m_ya + 1 : 0;
        nyb = (b == Y) ? m_yb + 1 : 0;
        nar = (a == R && b == R) ? m_ar + 1 : 0;
        case (m_mode)
            M_INIT: begin
                m_ya = nya; m_yb = nyb; m_ar = nar;
                m_pa = a; m_pb = b;
                m_mode = M_RUN;
            end
            M_RUN: begin
                v[1] = (a != R) && (b != R);
                v[2] = !model_legal(m_pa, a);
                v[3] = !model_legal(m_pb, b);
                v[4] = (m_pa == Y && a != Y && m_ya < YMIN) ||
                       (m_pb == Y && b != Y && m_yb < YMIN);
`ifdef TL_MON_WDOG_EN
                v[5] = (nar > ALLRED_MAX);
`else
                v[5] = 1'b0;
`endif
                m_ya = nya; m_yb = nyb; m_ar = nar;
                m_pa = a; m_pb = b;
                first = 0;
                for (int k = 5; k >= 1; k--) if (v[k]) first = k;
                if (first != 0) begin
                    m_mode = M_FAULT;
                    m_code = first;
                    m_fcyc = 0;
                end
            end
            default: begin
                if (c && a == R && b == R) model_reset();
                else m_fcyc++;
            end
        endcase
    endfunction

    task automatic tick(input logic [1:0] a, input logic [1:0] b, input logic c, input string ph);
        int exp_flash;
        @(negedge clk);
        La = a; Lb = b; clr = c;
        @(posedge clk);
        model_step(a, b, c);
        #1;
        exp_flash = (m_mode == M_FAULT && ((m_fcyc / FLASH_DIV) % 2) == 0) ? 1 : 0;
        check({ph, " fault"}, fault, (m_mode == M_FAULT) ? 1 : 0);
        check({ph, " code"}, fault_code, m_code);
        check({ph, " flash"}, flash, exp_flash);
    endtask

    task automatic rand_cycle();
        logic [1:0] a, b;
        logic c;
        a = cur_a; b = cur_b;
        c = ($urandom_range(0, 4) == 0);
        if (m_mode == M_FAULT && $urandom_range(0, 3) == 0) begin
            a = R; b = R; c = 1'b1;
        end else if ($urandom_range(0, 99) < 8) begin
            if ($urandom_range(0, 1) == 1) a = 2'($urandom_range(0, 3));
            else b = 2'($urandom_range(0, 3));
        end else if (a == R && b == R) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) a = ($urandom_range(0, 1) == 1) ? G : L;
                else b = ($urandom_range(0, 1) == 1) ? G : L;
            end
        end else begin
            if (a != R && $urandom_range(0, 2) == 0) a = (a == Y) ? R : Y;
            if (b != R && $urandom_range(0, 2) == 0) b = (b == Y) ? R : Y;
        end
        cur_a = a; cur_b = b;
        tick(a, b, c, "rand");
    endtask

    initial begin
        bit fexp [8] = '{1, 1, 1, 1, 0, 0, 0, 0};

        legal_tbl[R][G] = 1; legal_tbl[R][L] = 1;
        legal_tbl[G][Y] = 1; legal_tbl[L][Y] = 1; legal_tbl[Y][R] = 1;

        reset_n = 1'b0; La = R; Lb = R; clr = 1'b0;
        model_reset();
        cur_a = R; cur_b = R;
        #2;
        check("reset fault", fault, 0);
        check("reset code", fault_code, 0);
        check("reset flash", flash, 0);
        #10 reset_n = 1'b1;

        // normal road-A cycle then hand-over to road B
        tick(R, R, 0, "seq");
        repeat (3) tick(G, R, 0, "seq");
        repeat (2) tick(Y, R, 0, "seq");
        tick(R, R, 0, "seq");
        tick(R, G, 0, "seq");
        check("seq no fault", fault, 0);
        check("seq no code", fault_code, 0);

        // conflict and flash pattern; later violations must not overwrite the code
        tick(G, G, 0, "conf");
        check("conf code", fault_code, 1);
        check("flash 0", flash, fexp[0]);
        for (int i = 1; i < 8; i++) begin
            tick(G, R, 0, "flash");
            check($sformatf("flash %0d", i), flash, fexp[i]);
        end
        check("first code held", fault_code, 1);
        tick(G, G, 1, "clr nonred");
        check("clr nonred ignored", fault, 1);
        tick(R, R, 1, "clr");
        check("clr fault", fault, 0);

        // illegal transitions, lowest code wins
        tick(R, R, 0, "init");
        tick(G, R, 0, "ill");
        tick(R, R, 0, "ill a");
        check("ill a code", fault_code, 2);
        tick(R, R, 1, "clr");
        tick(G, R, 0, "init");
        tick(R, Y, 0, "ill ab");
        check("ill ab code", fault_code, 2);
        tick(R, R, 1, "clr");

        // short yellow, then clear and confirm INIT performs no check
        tick(R, R, 0, "init");
        tick(G, R, 0, "sy");
        tick(Y, R, 0, "sy");
        tick(R, R, 0, "sy");
        check("short yellow code", fault_code, 4);
        tick(R, R, 1, "clr");
        check("sy cleared", fault, 0);
        tick(G, G, 0, "init nocheck");
        check("init no check", fault, 0);
        tick(G, G, 0, "run conf");
        check("run conf code", fault_code, 1);
        tick(R, R, 1, "clr");

        // all-red watchdog
        tick(R, R, 0, "init");
        tick(G, R, 0, "wd");
        repeat (2) tick(Y, R, 0, "wd");
        repeat (8) tick(R, R, 0, "wd");
        check("wd 8 no fault", fault, 0);
        tick(R, R, 0, "wd");
`ifdef TL_MON_WDOG_EN
        check("wd 9 code", fault_code, 5);
`else
        repeat (11) tick(R, R, 0, "wd");
        check("wd off 20", fault, 0);
`endif

        // asynchronous reset between edges while faulted
        tick(G, G, 0, "pre areset");
        check("pre areset fault", fault, 1);
        reset_n = 1'b0;
        #1;
        check("areset fault", fault, 0);
        check("areset code", fault_code, 0);
        check("areset flash", flash, 0);
        #2 reset_n = 1'b1;
        model_reset();
        tick(G, G, 0, "restart init");
        tick(G, G, 0, "restart run");
        check("restart code", fault_code, 1);
        tick(R, R, 1, "clr");
        cur_a = R; cur_b = R;

        repeat (3000) rand_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
